// File: rtl/ball_motion_mod.sv
// ball_motion_mod: per-ball frame-rate position integrator with cushion reflection
// Friction decay is compiled in only when BALL_FRICTION_EN is defined.
module ball_motion_mod #(
    parameter int X_MIN = 45,
    parameter int X_MAX = 595,
    parameter int Y_MIN = 45,
    parameter int Y_MAX = 435,
    parameter int X_INIT = 160,
    parameter int Y_INIT = 240,
    parameter int V_MAX = 31,
    parameter int FRICTION_DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       upd_valid,
    input  logic [9:0] Vx_UPDATE,
    input  logic [9:0] Vy_UPDATE,
    input  logic [9:0] Dx_UPDATE,
    input  logic [9:0] Dy_UPDATE,
    output logic [9:0] xBall,
    output logic [9:0] yBall,
    output logic [9:0] Vx_NOW,
    output logic [9:0] Vy_NOW,
    output logic [9:0] Dx_NOW,
    output logic [9:0] Dy_NOW,
    output logic       moving,
    output logic       wall_hit
);
    typedef enum logic {STOP, MOVE} state_t;

    state_t state, state_n;
    logic [9:0] x, y, vx, vy, x_n, y_n, vx_n, vy_n, vx_ld, vy_ld;
    logic dx_neg, dy_neg, dx_neg_n, dy_neg_n, hit, hit_n, hx, hy;
    logic [11:0] sx, sy;
    logic unused_dir_bits;

    // Returns {hit, new_negative, new_position}; one reflection suffices since v <= V_MAX.
    function automatic logic [11:0] step(input logic [9:0] p, input logic [9:0] v,
                                         input logic neg, input int lo, input int hi);
        logic [10:0] raw, room;
        raw = {1'b0, p} + {1'b0, v};
        room = {1'b0, p} - 11'(lo);
        if (!neg)
            step = raw > 11'(hi) ? {2'b11, 10'(11'(2 * hi) - raw)} : {2'b00, raw[9:0]};
        else
            step = {1'b0, v} > room ? {2'b10, 10'(11'(2 * lo) + {1'b0, v} - {1'b0, p})}
                                    : {2'b01, 10'({1'b0, p} - {1'b0, v})};
    endfunction

    assign vx_ld = Vx_UPDATE > 10'(V_MAX) ? 10'(V_MAX) : Vx_UPDATE;
    assign vy_ld = Vy_UPDATE > 10'(V_MAX) ? 10'(V_MAX) : Vy_UPDATE;
    assign sx = step(x, vx, dx_neg, X_MIN, X_MAX);
    assign sy = step(y, vy, dy_neg, Y_MIN, Y_MAX);
    assign unused_dir_bits = ^{Dx_UPDATE[8:0], Dy_UPDATE[8:0]};

`ifdef BALL_FRICTION_EN
    localparam int CW = FRICTION_DIV > 1 ? $clog2(FRICTION_DIV) : 1;
    logic [CW-1:0] cnt, cnt_n;
`else
    localparam int unused_friction_div = FRICTION_DIV;
`endif

    always_comb begin
        state_n = state;
        x_n = x;
        y_n = y;
        vx_n = vx;
        vy_n = vy;
        dx_neg_n = dx_neg;
        dy_neg_n = dy_neg;
        hit_n = 1'b0;
        hx = 1'b0;
        hy = 1'b0;
`ifdef BALL_FRICTION_EN
        cnt_n = cnt;
`endif
        if (upd_valid) begin
            vx_n = vx_ld;
            vy_n = vy_ld;
            dx_neg_n = Dx_UPDATE[9];
            dy_neg_n = Dy_UPDATE[9];
            state_n = (vx_ld != 10'd0 || vy_ld != 10'd0) ? MOVE : STOP;
`ifdef BALL_FRICTION_EN
            cnt_n = '0;
`endif
        end else if (frame_tick && state == MOVE) begin
            {hx, dx_neg_n, x_n} = sx;
            {hy, dy_neg_n, y_n} = sy;
            hit_n = hx | hy;
`ifdef BALL_FRICTION_EN
            cnt_n = cnt + 1'b1;
            if (cnt == CW'(FRICTION_DIV - 1)) begin
                cnt_n = '0;
                vx_n = vx - 10'(vx != 10'd0);
                vy_n = vy - 10'(vy != 10'd0);
                state_n = (vx_n == 10'd0 && vy_n == 10'd0) ? STOP : MOVE;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STOP;
            x <= 10'(X_INIT);
            y <= 10'(Y_INIT);
            vx <= '0;
            vy <= '0;
            dx_neg <= 1'b0;
            dy_neg <= 1'b0;
            hit <= 1'b0;
`ifdef BALL_FRICTION_EN
            cnt <= '0;
`endif
        end else begin
            state <= state_n;
            x <= x_n;
            y <= y_n;
            vx <= vx_n;
            vy <= vy_n;
            dx_neg <= dx_neg_n;
            dy_neg <= dy_neg_n;
            hit <= hit_n;
`ifdef BALL_FRICTION_EN
            cnt <= cnt_n;
`endif
        end
    end

    assign xBall = x;
    assign yBall = y;
    assign Vx_NOW = vx;
    assign Vy_NOW = vy;
    assign Dx_NOW = {{9{dx_neg}}, 1'b1};
    assign Dy_NOW = {{9{dy_neg}}, 1'b1};
    assign moving = state == MOVE;
    assign wall_hit = hit;
endmodule

// File: tb/tb_ball_motion_mod.sv
// tb_ball_motion_mod: directed plus random stimulus, scoreboarded against an integer motion model.
module tb_ball_motion_mod;
    localparam int XMIN = 45, XMAX = 595, YMIN = 45, YMAX = 435, VMAX = 31, FDIV = 4;

    logic clk = 1'b0;
    logic rst, frame_tick, upd_valid;
    logic [9:0] vxu, vyu, dxu, dyu;
    logic [9:0] xBall, yBall, Vx_NOW, Vy_NOW, Dx_NOW, Dy_NOW;
    logic moving, wall_hit;

    always #5 clk = ~clk;

    ball_motion_mod #(.FRICTION_DIV(FDIV)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .upd_valid(upd_valid),
        .Vx_UPDATE(vxu), .Vy_UPDATE(vyu), .Dx_UPDATE(dxu), .Dy_UPDATE(dyu),
        .xBall(xBall), .yBall(yBall), .Vx_NOW(Vx_NOW), .Vy_NOW(Vy_NOW),
        .Dx_NOW(Dx_NOW), .Dy_NOW(Dy_NOW), .moving(moving), .wall_hit(wall_hit)
    );

    typedef struct packed {
        logic [9:0] x, y, vx, vy, dx, dy;
        logic mv, hit;
    } obs_t;

    obs_t q[$];
    obs_t e, a;
    int n_vec = 0, n_bad = 0;
    int mx, my, mvx, mvy, mdx, mdy, mcnt;
    bit mmv, mhit;

    // Move along the axis, folding back once across whichever bound was passed.
    function automatic void axis(inout int p, inout int d, input int v, input int lo,
                                 input int hi, inout bit h);
        p = p + d * v;
        if (p > hi) begin
            p = 2 * hi - p;
            d = -1;
            h = 1'b1;
        end else if (p < lo) begin
            p = 2 * lo - p;
            d = 1;
            h = 1'b1;
        end
    endfunction

    task automatic apply(input bit r, input bit t, input bit u, input int vx, input int vy,
                         input bit nx, input bit ny);
        obs_t o;
        @(negedge clk);
        rst = r;
        frame_tick = t;
        upd_valid = u;
        vxu = 10'(vx);
        vyu = 10'(vy);
        dxu = {nx, 9'($urandom)};
        dyu = {ny, 9'($urandom)};
        mhit = 1'b0;
        if (r) begin
            mx = 160; my = 240; mvx = 0; mvy = 0; mdx = 1; mdy = 1; mcnt = 0; mmv = 1'b0;
        end else if (u) begin
            mvx = vx > VMAX ? VMAX : vx;
            mvy = vy > VMAX ? VMAX : vy;
            mdx = nx ? -1 : 1;
            mdy = ny ? -1 : 1;
            mcnt = 0;
            mmv = (mvx != 0) || (mvy != 0);
        end else if (t && mmv) begin
            axis(mx, mdx, mvx, XMIN, XMAX, mhit);
            axis(my, mdy, mvy, YMIN, YMAX, mhit);
`ifdef BALL_FRICTION_EN
            mcnt++;
            if (mcnt == FDIV) begin
                mcnt = 0;
                if (mvx > 0) mvx--;
                if (mvy > 0) mvy--;
                if (mvx == 0 && mvy == 0) mmv = 1'b0;
            end
`endif
        end
        o = '{10'(mx), 10'(my), 10'(mvx), 10'(mvy), mdx < 0 ? 10'h3FF : 10'd1,
              mdy < 0 ? 10'h3FF : 10'd1, mmv, mhit};
        q.push_back(o);
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        apply(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic goto_x(input int tx);
        int d;
        for (int g = 0; g < 40 && mx != tx; g++) begin
            d = tx - mx;
            apply(1'b0, 1'b0, 1'b1, (d < 0 ? -d : d) > VMAX ? VMAX : (d < 0 ? -d : d), 0,
                  d < 0, 1'b0);
            tick();
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = '{xBall, yBall, Vx_NOW, Vy_NOW, Dx_NOW, Dy_NOW, moving, wall_hit};
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL vec%0d got x=%0d y=%0d vx=%0d vy=%0d dx=%h dy=%h mv=%b hit=%b want x=%0d y=%0d vx=%0d vy=%0d dx=%h dy=%h mv=%b hit=%b",
                         n_vec, a.x, a.y, a.vx, a.vy, a.dx, a.dy, a.mv, a.hit,
                         e.x, e.y, e.vx, e.vy, e.dx, e.dy, e.mv, e.hit);
            end
        end
    end

    initial begin
        rst = 1'b1;
        frame_tick = 1'b0;
        upd_valid = 1'b0;
        vxu = '0; vyu = '0; dxu = '0; dyu = '0;
        apply(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 5, 3, 1'b0, 1'b1);
        tick();
        goto_x(592);
        apply(1'b0, 1'b0, 1'b1, 5, 0, 1'b0, 1'b0);
        tick();
        idle();
        goto_x(590);
        apply(1'b0, 1'b0, 1'b1, 5, 0, 1'b0, 1'b0);
        tick();
        idle();
        apply(1'b0, 1'b0, 1'b1, 2, 0, 1'b1, 1'b0);
        repeat (12) tick();
        apply(1'b0, 1'b0, 1'b1, 5, 4, 1'b0, 1'b1);
        repeat (2) tick();
        apply(1'b0, 1'b1, 1'b1, 40, 0, 1'b0, 1'b0);
        repeat (5) tick();
        apply(1'b0, 1'b0, 1'b1, 20, 20, 1'b0, 1'b0);
        tick();
        apply(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b1, 9, 9, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3000; i++)
            apply($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 40), $urandom_range(0, 40),
                  1'($urandom), 1'($urandom));
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected outputs never compared, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ball_motion_mod.md
# ball_motion_mod

Per-ball motion integrator for the billiards table, sitting directly downstream of the ball-collision velocity update stage. Latches new speed magnitude and direction from the collision stage, advances the ball centre once per video frame, and reflects off the cushions. Applies friction decay until the ball stops. Feeds the current position and velocity back to the collision stage and to the pixel renderer.

## Interface
Parameters:
- X_MIN, 45: smallest legal ball-centre x (cushion edge + radius)
- X_MAX, 595: largest legal ball-centre x
- Y_MIN, 45: smallest legal ball-centre y
- Y_MAX, 435: largest legal ball-centre y
- X_INIT, 160: reset x position
- Y_INIT, 240: reset y position
- V_MAX, 31: speed magnitude clamp; must be ≤ min(X_MAX−X_MIN, Y_MAX−Y_MIN)
- FRICTION_DIV, 8: frame ticks per friction decrement (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- upd_valid  in  1  one-cycle strobe: load Vx/Vy/Dx/Dy_UPDATE
- Vx_UPDATE  in  10  new x speed magnitude
- Vy_UPDATE  in  10  new y speed magnitude
- Dx_UPDATE  in  10  new x direction; ±1 two's complement, only bit 9 used (1 = negative)
- Dy_UPDATE  in  10  new y direction, same encoding
- xBall  out  10  ball-centre x
- yBall  out  10  ball-centre y
- Vx_NOW  out  10  current x speed magnitude
- Vy_NOW  out  10  current y speed magnitude
- Dx_NOW  out  10  current x direction, 10'd1 or 10'h3FF
- Dy_NOW  out  10  current y direction
- moving  out  1  high while state is MOVE
- wall_hit  out  1  one-cycle pulse on any cushion reflection

## Operation
- States: STOP, MOVE. Reset → STOP.
- upd_valid (any state): Vx_NOW ← min(Vx_UPDATE, V_MAX), Vy_NOW likewise. Dx_NOW ← bit9 ? 10'h3FF : 10'd1, Dy_NOW likewise. Friction counter ← 0. State ← MOVE if either clamped magnitude is nonzero, else STOP.
- frame_tick in MOVE with no upd_valid: step each axis independently, using 11-bit intermediates.
  - Positive direction: raw = p + V. If raw > MAX, p ← 2·MAX − raw, direction ← negative, wall_hit.
  - Negative direction: if V > p − MIN, p ← 2·MIN + V − p, direction ← positive, wall_hit. Else p ← p − V.
  - A single reflection always suffices, because V ≤ V_MAX.
  - Reflection exactly at the bound (raw == MAX, or V == p − MIN) is not a hit: the ball lands on the bound and keeps its direction.
- Friction in the same tick: counter increments. When it reaches FRICTION_DIV−1, it wraps to 0 and each nonzero magnitude decrements by 1. When both magnitudes are 0 after a decrement, state ← STOP.
- frame_tick in STOP: no change; counter held at 0.
- upd_valid and frame_tick in the same cycle: the load wins and the tick is dropped entirely, with no step and no friction.
- Directions are retained in STOP.

## Timing
- All outputs registered.
- Reset values: xBall=X_INIT, yBall=Y_INIT, Vx_NOW=Vy_NOW=0, Dx_NOW=Dy_NOW=10'd1, moving=0, wall_hit=0.
- upd_valid at cycle n → new V/D and moving visible at n+1.
- frame_tick at cycle n → new xBall/yBall, V, D and wall_hit visible at n+1. wall_hit clears at n+2 unless re-triggered.
- rst mid-motion: all state returns to reset values next cycle. A pending tick or update in the reset cycle is ignored.
- Throughput: a tick every cycle is legal.

## Configuration
- BALL_FRICTION_EN defined: friction decay as above.
- Not defined: the counter is removed and magnitudes change only on upd_valid. The ball stays in MOVE indefinitely unless loaded with zero speeds. This mode is for cushion-reflection bring-up.

## Test plan
- Reset: hold rst 2 cycles. Required: xBall=160, yBall=240, V=0, D=1, moving=0, wall_hit=0.
- Load Vx=5 Dx=1, Vy=3 Dy=10'h3FF, then one tick. Required: xBall=165, yBall=237, moving=1, no wall_hit.
- x-cushion reflection:
  - At xBall=592, Vx=5 Dx=+ (X_MAX=595), tick → xBall=593, Dx_NOW=10'h3FF, one-cycle wall_hit.
  - At xBall=590, tick → 595, no hit.
- Friction (BALL_FRICTION_EN, FRICTION_DIV=4), Vx=2 Vy=0:
  - After tick 4: Vx=1.
  - After tick 8: Vx=0, moving=0.
  - Further ticks: xBall constant.
- Simultaneous upd_valid and tick with Vx_UPDATE=40 (V_MAX=31). Required: Vx_NOW=31, position unchanged, friction counter 0.
- rst asserted while moving with tick in the same cycle. Required: reset values next cycle, no wall_hit.
